// File: rtl/irq_pending_ctrl.sv
// Request capture front end: synchronises async request lines, latches rising edges
// as sticky pending bits and offers the highest-index enabled one over valid/ready.
module irq_pending_ctrl #(
  parameter int N_REQ       = 8,
  parameter int ID_W        = $clog2(N_REQ),
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] mask_i,
  input  logic [N_REQ-1:0] clr_i,
  input  logic             irq_ready_i,
  output logic             irq_valid_o,
  output logic [ID_W-1:0]  irq_id_o,
  output logic [N_REQ-1:0] pend_o,
  output logic             any_pend_o
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OFFER = 1'b1;

  logic [SYNC_STAGES-1:0][N_REQ-1:0] sync_q;
  logic [N_REQ-1:0] sync_dly_q;
  logic [N_REQ-1:0] edge_now;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic [N_REQ-1:0] clear_now;
  logic [N_REQ-1:0] eligible;
  logic [0:0]       state_q, state_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  hi_idx;
  logic             any_pend_q;
  logic             accept;

  // Synchroniser plus one history flop; the history flop resets low so a level
  // held across reset release still produces exactly one edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q     <= '0;
      sync_dly_q <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], req_i};
      sync_dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_now = sync_q[SYNC_STAGES-1] & ~sync_dly_q;
  assign accept   = irq_valid_o & irq_ready_i;
  assign eligible = pend_q & mask_i;

  // Set dominates clear so an edge coinciding with a clear is never dropped.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pend
    assign clear_now[gi] = clr_i[gi] | (accept & (id_q == ID_W'(gi)));
    assign pend_d[gi]    = (pend_q[gi] & ~clear_now[gi]) | edge_now[gi];
  end

  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (eligible[i]) hi_idx = ID_W'(i);
    end
  end

  // The offered id is frozen for the whole OFFER state: no preemption.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          id_d    = hi_idx;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (irq_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q     <= '0;
      state_q    <= IDLE;
      id_q       <= '0;
      any_pend_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      state_q    <= state_d;
      id_q       <= id_d;
      any_pend_q <= |eligible;
    end
  end

  assign irq_valid_o = (state_q == OFFER);
  assign irq_id_o    = id_q;
  assign pend_o      = pend_q;
  assign any_pend_o  = any_pend_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed checks of irq_pending_ctrl: latency, priority, masking, set/clear
// collision, offer persistence and asynchronous reset during an offer.
module tb_irq_pending_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [7:0] req_i, mask_i, clr_i;
  logic       irq_ready_i;
  logic       irq_valid_o;
  logic [2:0] irq_id_o;
  logic [7:0] pend_o;
  logic       any_pend_o;

  int n_assert = 0;
  int n_fail   = 0;

  irq_pending_ctrl dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .mask_i      (mask_i),
    .clr_i       (clr_i),
    .irq_ready_i (irq_ready_i),
    .irq_valid_o (irq_valid_o),
    .irq_id_o    (irq_id_o),
    .pend_o      (pend_o),
    .any_pend_o  (any_pend_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
      $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_offer(input string tag, input logic v, input logic [2:0] id);
    chk({tag, "_valid"}, {7'd0, irq_valid_o}, {7'd0, v});
    if (v) chk({tag, "_id"}, {5'd0, irq_id_o}, {5'd0, id});
  endtask

  initial begin
    rst_ni = 1'b0; req_i = 8'h00; mask_i = 8'hFF; clr_i = 8'h00; irq_ready_i = 1'b0;
    step(); step();
    chk("rst_valid", {7'd0, irq_valid_o}, 8'h00);
    chk("rst_id",    {5'd0, irq_id_o},    8'h00);
    chk("rst_pend",  pend_o,              8'h00);
    chk("rst_any",   {7'd0, any_pend_o},  8'h00);
    rst_ni = 1'b1;
    step(); step();

    // Single event on line 3
    req_i = 8'h08;
    step();                                   // edge 0
    step(); chk("t1_pend_e1", pend_o, 8'h00); // edge 1
    step(); chk("t1_pend_e2", pend_o, 8'h08);
    chk_offer("t1_e2", 1'b0, 3'd0);
    step(); chk_offer("t1_e3", 1'b1, 3'd3);
    chk("t1_any_e3", {7'd0, any_pend_o}, 8'h01);
    step(); chk_offer("t1_hold", 1'b1, 3'd3);
    req_i = 8'h00; irq_ready_i = 1'b1;
    step(); irq_ready_i = 1'b0;
    chk_offer("t1_acc", 1'b0, 3'd0);
    chk("t1_pend_acc", pend_o, 8'h00);
    step(); step(); step();
    chk("t1_any_idle", {7'd0, any_pend_o}, 8'h00);

    // Priority: lines 1 and 6 together, ready held high
    irq_ready_i = 1'b1; req_i = 8'h42;
    step(); step();
    step(); chk("t2_pend_e2", pend_o, 8'h42);
    step(); chk_offer("t2_first", 1'b1, 3'd6);
    step(); chk_offer("t2_bubble", 1'b0, 3'd0);
    chk("t2_pend_mid", pend_o, 8'h02);
    step(); chk_offer("t2_second", 1'b1, 3'd1);
    step(); chk_offer("t2_done", 1'b0, 3'd0);
    chk("t2_pend_end", pend_o, 8'h00);
    irq_ready_i = 1'b0; req_i = 8'h00;
    step(); step(); step();

    // Mask: line 5 disabled, then enabled
    mask_i = 8'hDF; req_i = 8'h20;
    step(); step(); step();
    chk("t3_pend", pend_o, 8'h20);
    step(); step();
    chk_offer("t3_masked", 1'b0, 3'd0);
    chk("t3_any", {7'd0, any_pend_o}, 8'h00);
    mask_i = 8'hFF;
    step(); chk_offer("t3_unmask", 1'b1, 3'd5);
    irq_ready_i = 1'b1;
    step(); irq_ready_i = 1'b0; req_i = 8'h00;
    chk("t3_pend_acc", pend_o, 8'h00);
    step(); step(); step();

    // Set/clear collision on line 2
    req_i = 8'h04;
    step(); req_i = 8'h00;                    // edge 0
    step(); req_i = 8'h04;                    // edge 1
    step(); chk("t4_pend_e2", pend_o, 8'h04);
    step(); chk_offer("t4_offer", 1'b1, 3'd2);
    clr_i = 8'h04;                            // second edge is live this cycle
    step(); clr_i = 8'h00;
    chk("t4_collide", pend_o, 8'h04);
    clr_i = 8'h04;
    step(); clr_i = 8'h00;
    chk("t4_clr", pend_o, 8'h00);
    chk_offer("t4_persist", 1'b1, 3'd2);
    irq_ready_i = 1'b1;
    step(); irq_ready_i = 1'b0; req_i = 8'h00;
    chk_offer("t4_acc", 1'b0, 3'd0);
    step(); step(); step(); step();

    // No preemption and stale offer
    req_i = 8'h04;
    step(); step(); step(); step();
    chk_offer("t5_offer", 1'b1, 3'd2);
    req_i = 8'h84; clr_i = 8'h04;
    step(); clr_i = 8'h00;
    chk("t5_pend_clr", pend_o, 8'h00);
    step(); step();
    chk("t5_pend_7", pend_o, 8'h80);
    chk_offer("t5_nopreempt", 1'b1, 3'd2);
    irq_ready_i = 1'b1;
    step(); irq_ready_i = 1'b0;
    chk("t5_pend_acc", pend_o, 8'h80);
    chk_offer("t5_acc", 1'b0, 3'd0);
    step(); chk_offer("t5_next", 1'b1, 3'd7);
    irq_ready_i = 1'b1;
    step(); irq_ready_i = 1'b0; req_i = 8'h00;
    chk("t5_pend_end", pend_o, 8'h00);
    step(); step(); step();

    // Asynchronous reset during an offer, line 4 held high across release
    req_i = 8'h10;
    step(); step(); step(); step();
    chk_offer("t6_offer", 1'b1, 3'd4);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_rst_valid", {7'd0, irq_valid_o}, 8'h00);
    chk("t6_rst_id",    {5'd0, irq_id_o},    8'h00);
    chk("t6_rst_pend",  pend_o,              8'h00);
    step(); step();
    #2 rst_ni = 1'b1;
    step(); step(); step();
    chk("t6_pend_e2", pend_o, 8'h10);
    chk_offer("t6_e2", 1'b0, 3'd0);
    step(); chk_offer("t6_reoffer", 1'b1, 3'd4);
    irq_ready_i = 1'b1;
    step(); irq_ready_i = 1'b0;
    chk("t6_pend_acc", pend_o, 8'h00);
    step(); step();
    chk_offer("t6_single", 1'b0, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_pending_ctrl.md
Name: irq_pending_ctrl

Overview:
- Upstream capture stage for the 8-to-3 priority encoding path.
- Synchronises 8 asynchronous request lines and detects rising edges. Holds them as sticky pending bits, applies an enable mask, and offers the highest-index enabled pending request as a 3-bit id over a valid/ready handshake.
- The id encoding matches the encoder convention: the highest set bit wins, so 8'b1XXXXXXX gives 7 and 8'b00000001 gives 0.

Parameters:
- N_REQ, 8, number of request lines (fixed at 8 for this revision).
- ID_W, 3, id width, $clog2(N_REQ).
- SYNC_STAGES, 2, synchroniser flops per request line (minimum 2).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- req_i  input  8  asynchronous level requests; a rising edge registers one event.
- mask_i  input  8  per-line enable, 1 = eligible for offer; does not gate pending capture.
- clr_i  input  8  synchronous per-bit pending clear, level-sampled each cycle.
- irq_ready_i  input  1  consumer accepts the offered id.
- irq_valid_o  output  1  an id is offered.
- irq_id_o  output  3  offered request index.
- pend_o  output  8  raw pending register.
- any_pend_o  output  1  OR of (pend & mask), registered view of pend_o.

Behaviour:
- Reset (async assert, sync release): sync flops, edge-history flops and pend are 0. irq_valid_o=0, irq_id_o=0, any_pend_o=0, FSM=IDLE.
- A req_i level held high across reset release counts as one rising edge after release.
- Sync: req_i passes through SYNC_STAGES flops. Edge = sync_out & ~sync_out_d, where sync_out_d is one more flop.
- Latency (SYNC_STAGES=2): req_i is first sampled high at edge 0. pend bit sets at edge 2. irq_valid_o is high after edge 3 if the bit is masked-in and FSM is IDLE.
- Pending update per bit each cycle: next = (pend & ~clear_now) | edge_now.
  - clear_now = clr_i[i] | (accept & irq_id_o==i), where accept = irq_valid_o & irq_ready_i.
  - Set wins over clear in the same cycle, so no event is lost.
  - A second edge while the bit is already pending is merged; there is no counting.
- eligible = pend & mask_i. any_pend_o is registered: any_pend_o <= |eligible.
- FSM, two states:
  - IDLE: if |eligible, latch irq_id_o = index of highest set bit of eligible, set irq_valid_o=1, go to OFFER. Otherwise stay.
  - OFFER: irq_valid_o and irq_id_o are held stable until accept; no preemption by higher-index arrivals.
  - On accept: clear pend[irq_id_o], irq_valid_o=0, return to IDLE. This leaves one bubble cycle between back-to-back offers.
- Offer persistence: valid never drops without ready. If the offered bit is unmasked or cleared via clr_i during OFFER, the offer still stands; the accept's clear is then a no-op unless a new edge sets the bit.
- mask_i changes take effect at the next IDLE evaluation only.
- irq_ready_i is ignored while irq_valid_o=0.
- Reset asserted mid-OFFER: immediate return to the reset values; all pending bits are lost.

Test Plan:
- Single event: pulse req_i[3] high for 5 cycles, mask_i=8'hFF, irq_ready_i=0. Required: pend_o=8'h08 after edge 2; after edge 3, valid=1 and id=3, held while ready=0. Assert ready for 1 cycle: valid=0 and pend_o=8'h00 next cycle.
- Priority: raise req_i[1] and req_i[6] in the same cycle, ready held high. Required: id=6 offered first; one idle cycle; then id=1; then pend_o=8'h00.
- Mask: req_i[5] edge with mask_i=8'hDF. Required: pend_o=8'h20, valid stays 0, any_pend_o=0. Set mask_i=8'hFF: valid=1 with id=5 within 2 cycles.
- Set/clear collision: pend[2]=1; drive clr_i[2]=1 in the same cycle a new req_i[2] edge is detected. Required: pend[2] stays 1.
- No preemption and stale offer: offer id=2 with ready=0, then raise req_i[7] and pulse clr_i[2]. Required: id stays 2 and valid stays 1. On accept, pend_o=8'h80 and the next offer is id=7.
- Reset mid-OFFER: valid=1 with id=4; drop rst_ni asynchronously between edges. Required: valid=0, id=0 and pend_o=0 immediately. After release with req_i[4] still high: one new event, and id=4 is offered 4 cycles later.
